md_pipe_sched: RTL

- Multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu from the E stage and holds the HI/LO registers.
- Counts the unit's busy period and drives stall/freeze controls to the PC, D and E pipeline registers.
- Stalls any D-stage HI/LO-class instruction (mfhi/mflo/mthi/mtlo/mult/div) while the unit is busy or starting.

---
 rtl/md_pipe_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/md_pipe_sched.sv
// Multiply/divide scheduler: owns HI/LO, times the busy period and stalls HI/LO-class D-stage instructions.
// Optional MD_FLUSH_EN adds a flush input that aborts a running operation and blocks IDLE-cycle requests.
//
// state | meaning
// IDLE  | accepts start or mthi/mtlo writes
// RUN   | counting down; result committed when cnt reaches 1
module md_pipe_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic [31:0] A_E,
   input  logic [31:0] B_E,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic        md_use_D,
`ifdef MD_FLUSH_EN
   input  logic        flush,
`endif
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        stall,
   output logic        en_PC,
   output logic        en_D,
   output logic        clr_E
);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   logic        state;
   logic [3:0]  cnt;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        flush_i;

   logic [63:0] prod_u, prod_s;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
   logic [31:0] res_hi, res_lo;
   logic        div_zero;

`ifdef MD_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
   always_comb begin
      prod_u = {32'b0, a_q} * {32'b0, b_q};
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      a_mag  = (op_q[0] && a_q[31]) ? -a_q : a_q;
      b_mag  = (op_q[0] && b_q[31]) ? -b_q : b_q;
      q_mag  = (b_mag == '0) ? '0 : a_mag / b_mag;
      r_mag  = (b_mag == '0) ? '0 : a_mag % b_mag;
      quo    = (op_q[0] && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
      rem    = (op_q[0] && a_q[31]) ? -r_mag : r_mag;
      if (op_q[1]) begin
         res_hi = rem;
         res_lo = quo;
      end else if (op_q[0]) begin
         res_hi = prod_s[63:32];
         res_lo = prod_s[31:0];
      end else begin
         res_hi = prod_u[63:32];
         res_lo = prod_u[31:0];
      end
      div_zero = op_q[1] && (b_q == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         HI    <= '0;
         LO    <= '0;
      end else if (state == IDLE) begin
         if (flush_i) begin
            state <= IDLE;
         end else if (start) begin
            op_q  <= md_op;
            a_q   <= A_E;
            b_q   <= B_E;
            cnt   <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            state <= RUN;
         end else begin
            if (wr_hi) HI <= A_E;
            if (wr_lo) LO <= A_E;
         end
      end else begin
         if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
               state <= IDLE;
               if (!div_zero) begin
                  HI <= res_hi;
                  LO <= res_lo;
               end
            end
         end
      end
   end

   assign busy  = (state == RUN);
   assign stall = md_use_D & (start | busy);
   assign en_PC = ~stall;
   assign en_D  = ~stall;
   assign clr_E = stall;

endmodule
